// File: rtl/fcmp_pipe_if.sv
// ============================================================================
// Module      : fcmp_pipe_if
// Description : Handshake bundle for the fcmp_pipe floating-point comparator.
//               Input side:  in_valid/in_ready, in_x1, in_x2, in_op, in_tag.
//               Output side: out_valid/out_ready, out_y, out_nan, out_tag,
//               and out_min when FCMP_MINMAX_EN is defined.
//               Modports: master (producer/consumer), slave (comparator).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fcmp_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x1;
  logic [W-1:0]     in_x2;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic             out_y;
  logic             out_nan;
  logic [TAG_W-1:0] out_tag;
`ifdef FCMP_MINMAX_EN
  logic [W-1:0]     out_min;
`endif

  modport master (
    output in_valid, in_x1, in_x2, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_nan, out_tag
`ifdef FCMP_MINMAX_EN
    , input out_min
`endif
  );

  modport slave (
    input  in_valid, in_x1, in_x2, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_nan, out_tag
`ifdef FCMP_MINMAX_EN
    , output out_min
`endif
  );

endinterface

`default_nettype wire

// File: rtl/fcmp_pipe.sv
// ============================================================================
// Module      : fcmp_pipe
// Description : Two-stage pipelined IEEE-style floating-point comparator
//               with valid/ready flow control.
//               Ops: 00 EQ, 01 LT, 10 LE, 11 NE. NaN operands force EQ/LT/LE
//               to 0 and NE to 1; out_nan flags any NaN operand.
//               Ports: clk, rst (sync, active-high), bus (fcmp_pipe_if.slave).
//               Stage 1 registers operand classification, stage 2 registers
//               the final result.
//               Optional feature macro: FCMP_MINMAX_EN adds out_min.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fcmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  fcmp_pipe_if.slave  bus
);

  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [1:0] OP_EQ = 2'b00;
  localparam logic [1:0] OP_LT = 2'b01;
  localparam logic [1:0] OP_LE = 2'b10;
  localparam logic [1:0] OP_NE = 2'b11;

  // --------------------------------------------------------------------------
  // Flow control
  // --------------------------------------------------------------------------
  logic w_s1_adv;
  logic w_s2_adv;
  logic r_s1_valid;
  logic r_out_valid;

  assign w_s2_adv     = ~r_out_valid | bus.out_ready;
  assign w_s1_adv     = ~r_s1_valid | w_s2_adv;
  assign bus.in_ready = w_s1_adv;

  // --------------------------------------------------------------------------
  // Front-end operand classification
  // --------------------------------------------------------------------------
  logic [W-2:0]     w_mag1;
  logic [W-2:0]     w_mag2;
  logic [EXP_W-1:0] w_exp1;
  logic [EXP_W-1:0] w_exp2;
  logic [MAN_W-1:0] w_man1;
  logic [MAN_W-1:0] w_man2;
  logic             w_nan1;
  logic             w_nan2;
  logic             w_both_zero_in;

  assign w_mag1 = bus.in_x1[W-2:0];
  assign w_mag2 = bus.in_x2[W-2:0];
  assign w_exp1 = w_mag1[W-2:MAN_W];
  assign w_exp2 = w_mag2[W-2:MAN_W];
  assign w_man1 = w_mag1[MAN_W-1:0];
  assign w_man2 = w_mag2[MAN_W-1:0];

  assign w_nan1 = (&w_exp1) & (|w_man1);
  assign w_nan2 = (&w_exp2) & (|w_man2);
  // Only the zero pair matters: a lone zero orders like any other magnitude.
  assign w_both_zero_in = ~(|w_mag1) & ~(|w_mag2);

  // --------------------------------------------------------------------------
  // Stage 1 registers
  // --------------------------------------------------------------------------
  logic             r_s1_sx1;
  logic             r_s1_sx2;
  logic             r_s1_nan1;
  logic             r_s1_nan2;
  logic             r_s1_both_zero;
  logic             r_s1_abs_lt;
  logic             r_s1_abs_eq;
  logic [1:0]       r_s1_op;
  logic [TAG_W-1:0] r_s1_tag;
`ifdef FCMP_MINMAX_EN
  logic [W-1:0]     r_s1_x1;
  logic [W-1:0]     r_s1_x2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      // Data registers only load on real transfers; a bubble leaves them as-is.
      if (bus.in_valid) begin
        r_s1_sx1       <= bus.in_x1[W-1];
        r_s1_sx2       <= bus.in_x2[W-1];
        r_s1_nan1      <= w_nan1;
        r_s1_nan2      <= w_nan2;
        r_s1_both_zero <= w_both_zero_in;
        r_s1_abs_lt    <= (w_mag1 < w_mag2);
        r_s1_abs_eq    <= (w_mag1 == w_mag2);
        r_s1_op        <= bus.in_op;
        r_s1_tag       <= bus.in_tag;
`ifdef FCMP_MINMAX_EN
        r_s1_x1        <= bus.in_x1;
        r_s1_x2        <= bus.in_x2;
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 combinational result
  // --------------------------------------------------------------------------
  logic w_eq;
  logic w_lt;
  logic w_any_nan;
  logic w_y;

  always_comb begin
    w_any_nan = r_s1_nan1 | r_s1_nan2;
    w_eq = r_s1_both_zero | ((r_s1_sx1 == r_s1_sx2) & r_s1_abs_eq);
    // Negative beats positive; two negatives order by reversed magnitude.
    w_lt = ~r_s1_both_zero &
           (( r_s1_sx1 & ~r_s1_sx2) |
            (~r_s1_sx1 & ~r_s1_sx2 &  r_s1_abs_lt) |
            ( r_s1_sx1 &  r_s1_sx2 & ~r_s1_abs_lt & ~r_s1_abs_eq));
    w_y = 1'b0;
    case (r_s1_op)
      OP_EQ:   w_y = w_eq;
      OP_LT:   w_y = w_lt;
      OP_LE:   w_y = w_lt | w_eq;
      OP_NE:   w_y = ~w_eq;
      default: w_y = 1'b0;
    endcase
    // Unordered: only NE is true.
    if (w_any_nan) begin
      w_y = (r_s1_op == OP_NE);
    end
  end

`ifdef FCMP_MINMAX_EN
  logic [W-1:0] w_min;

  always_comb begin
    w_min = r_s1_x2;
    if (r_s1_nan1 & ~r_s1_nan2) begin
      w_min = r_s1_x2;
    end else if (r_s1_nan2) begin
      // Covers the lone-NaN-in-x2 case and the both-NaN case alike.
      w_min = r_s1_x1;
    end else if (w_lt | w_eq) begin
      w_min = r_s1_x1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Stage 2 registers
  // --------------------------------------------------------------------------
  logic             r_out_y;
  logic             r_out_nan;
  logic [TAG_W-1:0] r_out_tag;
`ifdef FCMP_MINMAX_EN
  logic [W-1:0]     r_out_min;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_y     <= 1'b0;
      r_out_nan   <= 1'b0;
      r_out_tag   <= '0;
`ifdef FCMP_MINMAX_EN
      r_out_min   <= '0;
`endif
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_y   <= w_y;
        r_out_nan <= w_any_nan;
        r_out_tag <= r_s1_tag;
`ifdef FCMP_MINMAX_EN
        r_out_min <= w_min;
`endif
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_y     = r_out_y;
  assign bus.out_nan   = r_out_nan;
  assign bus.out_tag   = r_out_tag;
`ifdef FCMP_MINMAX_EN
  assign bus.out_min   = r_out_min;
`endif

endmodule

`default_nettype wire
